// File: rtl/fib_share_arbiter_if.sv
// fib_share_arbiter_if: bundles the requester side and the shared Fibonacci
// unit side of the arbiter into one connection.
//   req/n_in       requester levels and per-requester 4-bit indices
//   done/result/err  one-hot completion pulse, result and timeout flag
//   busy           arbiter not idle
//   fib_start/fib_n/fib_ready/fib_out  handshake with the shared unit
//   fsm_state      arbiter state, for observation only
// Unit handshake: fib_start is a single-cycle strobe that carries fib_n; the
// unit drops fib_ready after it sees the strobe and raises it again once
// fib_out holds the result. A job is complete only after fib_ready is seen
// low and then high again.
// Modports: master = the arbiter, slave = the surrounding environment.
interface fib_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] n_in;
  logic [NREQ-1:0]   done;
  logic [10:0]       result;
  logic              err;
  logic              busy;
  logic              fib_start;
  logic [3:0]        fib_n;
  logic              fib_ready;
  logic [10:0]       fib_out;
  logic [2:0]        fsm_state;

  modport master (
    input  req, n_in, fib_ready, fib_out,
    output done, result, err, busy, fib_start, fib_n, fsm_state
  );

  modport slave (
    output req, n_in, fib_ready, fib_out,
    input  done, result, err, busy, fib_start, fib_n, fsm_state
  );
endinterface

// File: rtl/fib_share_arbiter.sv
// fib_share_arbiter: round-robin sharing of one iterative Fibonacci unit
// among NREQ requesters. Indices 0 and 1 are answered directly without
// touching the unit, because the unit's counter never terminates for them.
// A watchdog converts a unit that never comes back into an error response.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  fib_share_arbiter_if.master (requesters, unit handshake, fsm_state)
module fib_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input logic                 clk,
  input logic                 rst,
  fib_share_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   winner_q;
  logic [3:0]      fib_n_q;
  logic [10:0]     res_q;
  logic            err_q;
  logic [WW-1:0]   wd_q;

  logic [IW-1:0]   pick;
  logic [3:0]      n_sel;
  logic            grant;
  logic            timeout;
  logic            unit_back;

  // First requester at or above ptr, wrapping at NREQ.
  always_comb begin : pick_blk
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign n_sel = bus.n_in[4*pick +: 4];

  // The unit carries no reset, so a grant also waits for it to be idle.
  assign grant     = (state_q == IDLE) && (|bus.req) && bus.fib_ready;
  assign unit_back = (state_q == WAIT_HIGH) && bus.fib_ready;
  // A result arriving on the last allowed cycle still wins over the timeout.
  assign timeout   = ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH)) &&
                     (wd_q == WW'(TIMEOUT - 1)) && !unit_back;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant) state_d = (n_sel < 4'd2) ? RESPOND : ISSUE;
      ISSUE:     state_d = WAIT_LOW;
      WAIT_LOW:  if (timeout) state_d = RESPOND;
                 else if (!bus.fib_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (unit_back || timeout) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      fib_n_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant) begin
            winner_q <= pick;
            err_q    <= 1'b0;
            wd_q     <= '0;
            if (n_sel < 4'd2) res_q <= {7'd0, n_sel};
            else              fib_n_q <= n_sel;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          wd_q <= wd_q + WW'(1);
          if (unit_back) begin
            res_q <= bus.fib_out;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESPOND: begin
          if (winner_q == IW'(NREQ - 1)) ptr_q <= '0;
          else                           ptr_q <= winner_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Completion outputs are qualified by RESPOND so they read 0 otherwise.
  assign bus.done      = (state_q == RESPOND) ? (NREQ'(1) << winner_q) : '0;
  assign bus.result    = (state_q == RESPOND) ? res_q : '0;
  assign bus.err       = (state_q == RESPOND) && err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.fib_start = (state_q == ISSUE);
  assign bus.fib_n     = fib_n_q;
  assign bus.fsm_state = 3'(state_q);

endmodule

// File: tb/tb_fib_share_arbiter.sv
// tb_fib_share_arbiter: directed test of fib_share_arbiter with a stub
// Fibonacci unit, a job-level reference model compared every cycle, and
// hand-computed expectations for each directed job.
module tb_fib_share_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_share_arbiter_if #(.NREQ(NREQ)) bus ();

  fib_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0]   req_v = '0;
  logic [4*NREQ-1:0] n_v   = '0;
  logic              unit_ready = 1'b1;
  logic [10:0]       unit_out   = '0;
  logic              unit_stuck = 1'b0;

  assign bus.req       = req_v;
  assign bus.n_in      = n_v;
  assign bus.fib_ready = unit_ready;
  assign bus.fib_out   = unit_out;

  int checks = 0;
  int errors = 0;

  function automatic int fib_f(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stub Fibonacci unit ----------------
  // Drops ready after seeing start, keeps it low n-1 cycles, then presents
  // fib(n). When unit_stuck is set at start it never returns until released.
  int unit_cnt  = 0;
  int unit_n    = 0;
  bit unit_hold = 1'b0;
  always @(posedge clk) begin
    if (unit_cnt > 0) begin
      unit_cnt--;
      if (unit_cnt == 0) begin
        unit_ready <= 1'b1;
        unit_out   <= 11'(fib_f(unit_n));
      end
    end else if (unit_hold) begin
      if (!unit_stuck) begin
        unit_hold = 1'b0;
        unit_ready <= 1'b1;
      end
    end else if (bus.fib_start) begin
      unit_ready <= 1'b0;
      unit_n = int'(bus.fib_n);
      if (unit_stuck) unit_hold = 1'b1;
      else            unit_cnt  = unit_n - 1;
    end
  end

  // ---------------- reference model ----------------
  // Job level: a grant happens at the end of an idle cycle with a request
  // and a ready unit; the job then occupies cycles 0..d after the grant,
  // with done in cycle d, followed by at least one idle cycle.
  bit          m_valid = 1'b0;
  bit          m_act   = 1'b0;
  int          m_ptr = 0, m_t = 0, m_d = 0, m_win = 0, m_n = 0, m_res = 0;
  bit          m_err = 1'b0;
  logic [3:0]  m_last_n = '0;
  logic [NREQ-1:0] e_done  = '0;
  logic [10:0]     e_res   = '0;
  logic            e_err   = 1'b0;
  logic            e_busy  = 1'b0;
  logic            e_start = 1'b0;
  logic [3:0]      e_fib_n = '0;

  always @(posedge clk) begin
    bit found;
    int idx;
    m_valid = 1'b1;
    if (rst) begin
      m_act    = 1'b0;
      m_ptr    = 0;
      m_last_n = '0;
    end else if (m_act) begin
      m_t++;
      if (m_t > m_d) begin
        m_act = 1'b0;
        m_ptr = (m_win + 1) % NREQ;
      end
    end else if (req_v != '0 && unit_ready) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req_v[idx]) begin
          found = 1'b1;
          m_win = idx;
        end
      end
      m_n   = int'(n_v[4*m_win +: 4]);
      m_act = 1'b1;
      m_t   = 0;
      if (m_n < 2) begin
        m_d = 0; m_err = 1'b0; m_res = m_n;
      end else begin
        m_last_n = 4'(m_n);
        if (unit_stuck) begin
          m_d = TIMEOUT + 1; m_err = 1'b1; m_res = 0;
        end else begin
          m_d = m_n + 1; m_err = 1'b0; m_res = fib_f(m_n);
        end
      end
    end
    e_busy  = m_act;
    e_start = m_act && (m_t == 0) && (m_n >= 2);
    e_done  = (m_act && m_t == m_d) ? (NREQ'(1) << m_win) : '0;
    e_res   = (m_act && m_t == m_d) ? 11'(m_res) : '0;
    e_err   = m_act && (m_t == m_d) && m_err;
    e_fib_n = m_last_n;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("result",    32'(bus.result),    32'(e_res));
      chk("err",       32'(bus.err),       32'(e_err));
      chk("fib_start", 32'(bus.fib_start), 32'(e_start));
      chk("fib_n",     32'(bus.fib_n),     32'(e_fib_n));
    end
  end

  // ---------------- driver tasks ----------------
  int   rearm   [NREQ];
  bit   lowered [NREQ];

  // Advance one cycle; a requester drops req at the edge ending its done
  // cycle and, if rearmed, raises it again one cycle later.
  task automatic tick();
    logic [NREQ-1:0] d;
    d = bus.done;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (lowered[i] && rearm[i] > 0) begin
        req_v[i]   = 1'b1;
        rearm[i]   = rearm[i] - 1;
        lowered[i] = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (d[i]) begin
        req_v[i]   = 1'b0;
        lowered[i] = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    req_v = '0;
    rst   = 1'b1;
    repeat (3) tick();
    rst   = 1'b0;
  endtask

  // Waits for the next done pulse; cyc counts ticks minus one (cycle index
  // relative to the grant edge when called in the cycle before the grant).
  task automatic wait_done(input logic [3:0] n, input bit check_n,
                           output int cyc, output logic [NREQ-1:0] d,
                           output logic [10:0] r, output logic e,
                           output int starts, output int bad_n);
    bit got;
    got = 1'b0; cyc = -1; d = '0; r = '0; e = 1'b0; starts = 0; bad_n = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      if (bus.fib_start) starts++;
      if (check_n && bus.busy && bus.fib_n != n) bad_n++;
      if (bus.done != '0) begin
        got = 1'b1; cyc = c; d = bus.done; r = bus.result; e = bus.err;
      end
    end
  endtask

  task automatic run_job(input string nm, input int who, input logic [3:0] n,
                         input bit stuck, input int exp_res, input bit exp_err,
                         input int exp_lat, input bit check_n);
    int cyc, starts, bad_n;
    logic [NREQ-1:0] d;
    logic [10:0] r;
    logic e;
    n_v[4*who +: 4] = n;
    unit_stuck = stuck;
    req_v[who] = 1'b1;
    wait_done(n, check_n, cyc, d, r, e, starts, bad_n);
    unit_stuck = 1'b0;
    chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, " done"},    32'(d),   32'(NREQ'(1) << who));
    chk({nm, " result"},  32'(r),   32'(exp_res));
    chk({nm, " err"},     32'(e),   32'(exp_err));
    chk({nm, " starts"},  32'(starts), (n < 2) ? 32'd0 : 32'd1);
    if (check_n) chk({nm, " fib_n held"}, 32'(bad_n), 32'd0);
    tick();
    tick();
  endtask

  task automatic all_four();
    int got_w[5];
    int got_r[5];
    int exp_w[5] = '{0, 1, 2, 3, 0};
    int exp_r[5] = '{1, 2, 3, 5, 1};
    int cnt;
    apply_reset();
    n_v = {4'd5, 4'd4, 4'd3, 4'd2};
    for (int i = 0; i < NREQ; i++) begin
      rearm[i]   = 0;
      lowered[i] = 1'b0;
    end
    rearm[0] = 1;
    req_v = 4'b1111;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 5; c++) begin
      tick();
      if (bus.done != '0) begin
        for (int i = 0; i < NREQ; i++)
          if (bus.done[i]) got_w[cnt] = i;
        got_r[cnt] = int'(bus.result);
        cnt++;
      end
    end
    chk("rr job count", 32'(cnt), 32'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < cnt) begin
        chk($sformatf("rr winner %0d", j), 32'(got_w[j]), 32'(exp_w[j]));
        chk($sformatf("rr result %0d", j), 32'(got_r[j]), 32'(exp_r[j]));
      end
    end
    repeat (3) tick();
  endtask

  task automatic reset_mid_job();
    int cyc, starts, bad_n, quiet_bad;
    logic [NREQ-1:0] d;
    logic [10:0] r;
    logic e;
    n_v[11:8]  = 4'd6;
    unit_stuck = 1'b1;
    req_v[2]   = 1'b1;
    repeat (5) tick();
    chk("rstjob busy before", 32'(bus.busy), 32'd1);
    chk("rstjob unit low",    32'(bus.fib_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstjob busy",   32'(bus.busy),      32'd0);
    chk("rstjob start",  32'(bus.fib_start), 32'd0);
    chk("rstjob fib_n",  32'(bus.fib_n),     32'd0);
    chk("rstjob result", 32'(bus.result),    32'd0);
    quiet_bad = 0;
    repeat (6) begin
      tick();
      if (bus.busy || bus.fib_start || bus.done != '0) quiet_bad++;
    end
    chk("rstjob no grant while unit low", 32'(quiet_bad), 32'd0);
    unit_stuck = 1'b0;
    wait_done(4'd6, 1'b0, cyc, d, r, e, starts, bad_n);
    chk("rstjob regrant latency", 32'(cyc), 32'd8);
    chk("rstjob done",   32'(d), 32'b0100);
    chk("rstjob result", 32'(r), 32'd8);
    chk("rstjob starts", 32'(starts), 32'd1);
    tick();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rearm[i]   = 0;
      lowered[i] = 1'b0;
    end
    apply_reset();
    chk("reset busy",   32'(bus.busy),      32'd0);
    chk("reset done",   32'(bus.done),      32'd0);
    chk("reset start",  32'(bus.fib_start), 32'd0);
    chk("reset fib_n",  32'(bus.fib_n),     32'd0);
    chk("reset result", 32'(bus.result),    32'd0);
    chk("reset err",    32'(bus.err),       32'd0);

    run_job("n10 req2",  2, 4'd10, 1'b0, 55,  1'b0, 11, 1'b0);
    run_job("n0 req0",   0, 4'd0,  1'b0, 0,   1'b0, 0,  1'b0);
    run_job("n1 req0",   0, 4'd1,  1'b0, 1,   1'b0, 0,  1'b0);
    run_job("n15 req3",  3, 4'd15, 1'b0, 610, 1'b0, 16, 1'b1);
    run_job("n2 req1",   1, 4'd2,  1'b0, 1,   1'b0, 3,  1'b0);
    all_four();
    run_job("timeout",   1, 4'd7,  1'b1, 0,   1'b1, TIMEOUT + 1, 1'b1);
    tick();
    run_job("after tmo", 1, 4'd3,  1'b0, 2,   1'b0, 4,  1'b0);
    reset_mid_job();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
